// File: rtl/hdmi_fetch_sched.sv
// hdmi_fetch_sched
// Turns HDMI frame/line timing into DDR master burst-read commands that keep
// the pixel FIFO topped up. Each visible line is fetched as a run of bursts of
// at most BURST_BYTES; a burst is only requested once the FIFO has room for
// all of it, so the bus master never has to stall on a full FIFO.
module hdmi_fetch_sched #(
    parameter int BURST_BYTES = 128,
    parameter int FIFO_DEPTH  = 512,
    parameter int CNT_W       = 10
) (
    input  logic             Bus2IP_Clk,
    input  logic             Bus2IP_Resetn,
    input  logic             enable,
    input  logic [31:0]      frame_base,
    input  logic [31:0]      line_stride,
    input  logic [31:0]      bytes_per_pixel,
    input  logic [10:0]      hres,
    input  logic [9:0]       vres,
    input  logic             frame_start,
    input  logic             frame_done,
    input  logic [CNT_W-1:0] fifo_count,
    output logic             ip2bus_mstrd_req,
    output logic [31:0]      ip2bus_mst_addr,
    output logic [11:0]      ip2bus_mst_length,
    input  logic             bus2ip_mst_cmdack,
    input  logic             bus2ip_mst_cmplt,
    input  logic             bus2ip_mst_error,
    output logic             busy,
    output logic [9:0]       line_idx,
    output logic             err_sticky
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT     = 3'd1;
    localparam logic [2:0] S_REQ      = 3'd2;
    localparam logic [2:0] S_XFER     = 3'd3;
    localparam logic [2:0] S_LINE_END = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [12:0] BURST_MAX = 13'(BURST_BYTES);

    logic [2:0]       state;
    logic [31:0]      line_addr;
    logic [31:0]      burst_addr;
    logic [12:0]      remaining;
    logic [31:0]      stride_x4;
    logic [CNT_W-1:0] fifo_q;
    logic             restart_pend;

    logic [12:0]      line_bytes;
    logic [12:0]      len;
    logic [31:0]      fifo_free;
    logic             space_ok;
    logic             frame_empty;
    logic             last_line;
    logic             reload;

    // Pixels are always 4 bytes, so the pixel-size register and the stride
    // bits shifted out by the x4 scaling carry no information here.
    wire unused_cfg = &{1'b0, bytes_per_pixel, line_stride[31:30]};

    // Burst sizing, FIFO room and frame (re)load decisions for the current cycle
    always_comb begin
        line_bytes  = {hres, 2'b00};
        len         = (remaining < BURST_MAX) ? remaining : BURST_MAX;
        fifo_free   = (32'(fifo_q) >= 32'(FIFO_DEPTH)) ? 32'd0
                                                       : 32'(FIFO_DEPTH) - 32'(fifo_q);
        space_ok    = fifo_free >= {19'd0, len >> 2};
        frame_empty = (hres == 11'd0) || (vres == 10'd0);
        last_line   = (line_idx == (vres - 10'd1));
        reload      = 1'b0;
        case (state)
            S_IDLE:             reload = frame_start && enable;
            S_DONE:             reload = (frame_start || restart_pend) && enable;
            S_WAIT, S_LINE_END: reload = restart_pend;
            default:            reload = 1'b0;
        endcase
    end

    // Fetch sequencer: frame load, burst issue, completion and line stepping
    always_ff @(posedge Bus2IP_Clk) begin
        if (!Bus2IP_Resetn) begin
            state             <= S_IDLE;
            line_addr         <= 32'd0;
            burst_addr        <= 32'd0;
            remaining         <= 13'd0;
            stride_x4         <= 32'd0;
            fifo_q            <= '0;
            restart_pend      <= 1'b0;
            ip2bus_mstrd_req  <= 1'b0;
            ip2bus_mst_addr   <= 32'd0;
            ip2bus_mst_length <= 12'd0;
            busy              <= 1'b0;
            line_idx          <= 10'd0;
            err_sticky        <= 1'b0;
        end else begin
            fifo_q    <= fifo_count;
            stride_x4 <= {line_stride[29:0], 2'b00};

            if (frame_start && busy) begin
                restart_pend <= 1'b1;
            end else if (reload || state == S_IDLE) begin
                restart_pend <= 1'b0;
            end

            if (reload) begin
                line_addr  <= frame_base;
                burst_addr <= frame_base;
                line_idx   <= 10'd0;
                remaining  <= line_bytes;
                if (frame_empty) begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                end else begin
                    state <= S_WAIT;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        busy <= 1'b0;
                    end
                    S_WAIT: begin
                        if (enable && space_ok) begin
                            ip2bus_mst_addr   <= burst_addr;
                            ip2bus_mst_length <= len[11:0];
                            ip2bus_mstrd_req  <= 1'b1;
                            state             <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        if (bus2ip_mst_cmdack) begin
                            ip2bus_mstrd_req <= 1'b0;
                            state            <= S_XFER;
                        end
                    end
                    S_XFER: begin
                        if (bus2ip_mst_cmplt) begin
                            burst_addr <= burst_addr + {19'd0, len};
                            remaining  <= remaining - len;
                            if (bus2ip_mst_error) begin
                                err_sticky <= 1'b1;
                            end
                            state <= (remaining == len) ? S_LINE_END : S_WAIT;
                        end
                    end
                    S_LINE_END: begin
                        if (last_line) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                        end else begin
                            line_idx   <= line_idx + 10'd1;
                            line_addr  <= line_addr + stride_x4;
                            burst_addr <= line_addr + stride_x4;
                            remaining  <= line_bytes;
                            state      <= S_WAIT;
                        end
                    end
                    S_DONE: begin
                        busy <= 1'b0;
                        if (frame_done || frame_start) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state            <= S_IDLE;
                        ip2bus_mstrd_req <= 1'b0;
                        busy             <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdmi_fetch_sched.sv
// tb_hdmi_fetch_sched
// Drives frames through hdmi_fetch_sched, plays the bus master with random
// ack/complete delays, and compares every command against a list of bursts
// computed directly from the frame geometry.
module tb_hdmi_fetch_sched;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [31:0] frame_base;
    logic [31:0] line_stride;
    logic [31:0] bytes_per_pixel;
    logic [10:0] hres;
    logic [9:0]  vres;
    logic        frame_start;
    logic        frame_done;
    logic [9:0]  fifo_count;
    logic        req;
    logic [31:0] addr;
    logic [11:0] length;
    logic        cmdack;
    logic        cmplt;
    logic        merr;
    logic        busy;
    logic [9:0]  line_idx;
    logic        err_sticky;

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          line;
    } cmd_t;

    cmd_t expQ[$];
    int   testsRun  = 0;
    int   failCount = 0;
    logic expErr    = 1'b0;

    hdmi_fetch_sched dut (
        .Bus2IP_Clk        (clk),
        .Bus2IP_Resetn     (resetn),
        .enable            (enable),
        .frame_base        (frame_base),
        .line_stride       (line_stride),
        .bytes_per_pixel   (bytes_per_pixel),
        .hres              (hres),
        .vres              (vres),
        .frame_start       (frame_start),
        .frame_done        (frame_done),
        .fifo_count        (fifo_count),
        .ip2bus_mstrd_req  (req),
        .ip2bus_mst_addr   (addr),
        .ip2bus_mst_length (length),
        .bus2ip_mst_cmdack (cmdack),
        .bus2ip_mst_cmplt  (cmplt),
        .bus2ip_mst_error  (merr),
        .busy              (busy),
        .line_idx          (line_idx),
        .err_sticky        (err_sticky)
    );

    // Free-running bus clock
    always #5 clk = ~clk;

    // Hard stop in case the design wedges somewhere the bounded waits miss
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected burst list straight from the frame geometry
    task automatic buildFrame(input logic [31:0] base, input logic [31:0] stride, input int h, input int v);
        expQ.delete();
        if (h == 0 || v == 0) return;
        for (int l = 0; l < v; l++) begin
            logic [31:0] a;
            int rem;
            a   = base + 32'(l) * stride * 32'd4;
            rem = h * 4;
            while (rem > 0) begin
                cmd_t c;
                c.len  = (rem < 128) ? rem : 128;
                c.addr = a;
                c.line = l;
                expQ.push_back(c);
                a   = a + 32'(c.len);
                rem = rem - c.len;
            end
        end
    endtask

    task automatic setConfig(input logic [31:0] base, input logic [31:0] stride, input int h, input int v);
        frame_base  = base;
        line_stride = stride;
        hres        = 11'(h);
        vres        = 10'(v);
    endtask

    task automatic pulseStart();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Act as the bus master for every burst still expected in this frame
    task automatic serveQueue(input int firstGap, input int ackD, input int cmpltD, input int errPct);
        int gap;
        gap = firstGap;
        while (expQ.size() > 0) begin
            cmd_t e;
            int   n;
            bit   doErr;
            e = expQ.pop_front();
            n = 0;
            do begin
                tick();
                n++;
            end while (!req && n < 20);
            if (!req) begin
                checkOutput("req_timeout", 32'(req), 32'd1);
                expQ.delete();
                return;
            end
            checkOutput("req_gap", 32'(n), 32'(gap));
            checkOutput("cmd_addr", addr, e.addr);
            checkOutput("cmd_len", 32'(length), 32'(e.len));
            checkOutput("cmd_line", 32'(line_idx), 32'(e.line));
            for (int j = 0; j < ackD; j++) begin
                tick();
                checkOutput("req_hold", 32'(req), 32'd1);
            end
            cmdack = 1'b1;
            tick();
            cmdack = 1'b0;
            checkOutput("req_drop", 32'(req), 32'd0);
            for (int j = 0; j < cmpltD; j++) tick();
            doErr = ($urandom_range(0, 99) < errPct);
            cmplt = 1'b1;
            merr  = doErr;
            tick();
            cmplt = 1'b0;
            merr  = 1'b0;
            if (doErr) expErr = 1'b1;
            checkOutput("err_sticky", 32'(err_sticky), 32'(expErr));
            if (expQ.size() > 0) gap = (expQ[0].line != e.line) ? 2 : 1;
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            checkOutput("no_extra_req", 32'(req), 32'd0);
        end
        checkOutput("busy_end", 32'(busy), 32'd0);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] stride, input int h, input int v,
                                 input int ackD, input int cmpltD, input int errPct);
        setConfig(base, stride, h, v);
        buildFrame(base, stride, h, v);
        pulseStart();
        checkOutput("busy_start", 32'(busy), (expQ.size() > 0) ? 32'd1 : 32'd0);
        serveQueue(1, ackD, cmpltD, errPct);
    endtask

    // Directed scenarios followed by randomized frames
    initial begin
        resetn          = 1'b0;
        enable          = 1'b1;
        frame_base      = 32'd0;
        line_stride     = 32'd0;
        bytes_per_pixel = 32'd4;
        hres            = 11'd0;
        vres            = 10'd0;
        frame_start     = 1'b0;
        frame_done      = 1'b0;
        fifo_count      = 10'd0;
        cmdack          = 1'b0;
        cmplt           = 1'b0;
        merr            = 1'b0;

        repeat (3) tick();
        checkOutput("rst_req", 32'(req), 32'd0);
        checkOutput("rst_addr", addr, 32'd0);
        checkOutput("rst_len", 32'(length), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_line", 32'(line_idx), 32'd0);
        checkOutput("rst_err", 32'(err_sticky), 32'd0);
        resetn = 1'b1;
        tick();

        // Frame start is ignored while disabled
        enable = 1'b0;
        setConfig(32'h0000_4000, 32'd64, 64, 1);
        pulseStart();
        for (int j = 0; j < 3; j++) begin
            tick();
            checkOutput("dis_busy", 32'(busy), 32'd0);
            checkOutput("dis_req", 32'(req), 32'd0);
        end
        enable = 1'b1;

        applyStimulus(32'hA800_0000, 32'd64, 64, 2, 3, 3, 0);
        applyStimulus(32'h2000_0000, 32'd50, 40, 2, 0, 1, 0);
        applyStimulus(32'h3000_0000, 32'd32, 32, 1, 1, 0, 100);
        applyStimulus(32'h5000_0000, 32'd16, 0, 3, 0, 0, 0);
        applyStimulus(32'h5000_0000, 32'd16, 16, 0, 0, 0, 0);

        for (int f = 0; f < 10; f++) begin
            int h;
            int v;
            h = $urandom_range(0, 200);
            v = $urandom_range(0, 4);
            fifo_count = 10'($urandom_range(0, 480));
            applyStimulus({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 32'(h + $urandom_range(0, 50)),
                          h, v, $urandom_range(0, 3), $urandom_range(0, 4), 20);
        end
        fifo_count = 10'd0;

        // Restart while a burst is outstanding
        setConfig(32'h6000_0000, 32'd80, 64, 2);
        buildFrame(32'h6000_0000, 32'd80, 64, 2);
        pulseStart();
        begin
            int n;
            n = 0;
            do begin
                tick();
                n++;
            end while (!req && n < 20);
            checkOutput("rs_first_req", 32'(req), 32'd1);
            checkOutput("rs_first_addr", addr, 32'h6000_0000);
        end
        cmdack = 1'b1;
        tick();
        cmdack = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            checkOutput("rs_no_req", 32'(req), 32'd0);
            tick();
        end
        cmplt = 1'b1;
        tick();
        cmplt = 1'b0;
        buildFrame(32'h6000_0000, 32'd80, 64, 2);
        serveQueue(2, 1, 2, 0);

        // FIFO backpressure, then reset while the request is pending
        checkOutput("bp_err_before", 32'(err_sticky), 32'd1);
        setConfig(32'h0000_1000, 32'd64, 64, 1);
        fifo_count = 10'd496;
        pulseStart();
        for (int j = 0; j < 8; j++) begin
            tick();
            checkOutput("bp_hold", 32'(req), 32'd0);
        end
        fifo_count = 10'd480;
        tick();
        checkOutput("bp_latency", 32'(req), 32'd0);
        tick();
        checkOutput("bp_req", 32'(req), 32'd1);
        checkOutput("bp_addr", addr, 32'h0000_1000);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        expErr = 1'b0;
        checkOutput("rr_req", 32'(req), 32'd0);
        checkOutput("rr_busy", 32'(busy), 32'd0);
        checkOutput("rr_err", 32'(err_sticky), 32'd0);
        fifo_count = 10'd0;
        for (int j = 0; j < 8; j++) begin
            tick();
            checkOutput("rr_no_req", 32'(req), 32'd0);
        end

        applyStimulus(32'h7000_0100, 32'd100, 72, 2, 2, 1, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/hdmi_fetch_sched.md
# hdmi_fetch_sched

Fetch scheduler for the HDMI output path. It turns the frame and line timing events from the HDMI core into a sequence of DDR master burst-read commands that fill the pixel FIFO. It sits between the HDMI core, the pixel FIFO's write-side occupancy count and the bus master read interface, and it replaces the free-running address generator. Configuration comes from slave registers.

## Interface

Parameters:
- BURST_BYTES, 128, maximum bytes per master read command; must be a power of two and a multiple of 4.
- FIFO_DEPTH, 512, pixel FIFO depth in 32-bit words.
- CNT_W, 10, width of the FIFO occupancy count.

Ports:
- Bus2IP_Clk  in  1  single clock for all logic.
- Bus2IP_Resetn  in  1  synchronous, active-low reset.
- enable  in  1  slave-register enable; while low, no new command is issued.
- frame_base  in  32  byte address of pixel (0,0).
- line_stride  in  32  pixels per line in memory.
- bytes_per_pixel  in  32  bytes per pixel; only 4 is supported.
- hres  in  11  visible pixels per line.
- vres  in  10  visible lines per frame.
- frame_start  in  1  one-cycle pulse (HDMI core read_go); starts or restarts a frame.
- frame_done  in  1  one-cycle pulse (HDMI core read_done).
- fifo_count  in  CNT_W  words currently held in the pixel FIFO.
- ip2bus_mstrd_req  out  1  read command request.
- ip2bus_mst_addr  out  32  burst byte address.
- ip2bus_mst_length  out  12  burst length in bytes.
- bus2ip_mst_cmdack  in  1  command accepted.
- bus2ip_mst_cmplt  in  1  burst data fully written to the FIFO.
- bus2ip_mst_error  in  1  burst error; valid together with cmplt.
- busy  out  1  a frame fetch is in progress.
- line_idx  out  10  line currently being fetched.
- err_sticky  out  1  a burst error has occurred since reset.

## Operation

- **State IDLE.**
  - On frame_start with enable=1: load line_addr=frame_base, line_idx=0, remaining=hres*4 (13 bits), set busy=1, go to WAIT_SPACE.
- **State WAIT_SPACE.**
  - len = min(remaining, BURST_BYTES).
  - When FIFO_DEPTH − fifo_count ≥ len/4 and enable=1, register the address and length and go to REQ.
- **State REQ.**
  - Hold ip2bus_mstrd_req=1 with stable address and length until the cycle in which cmdack=1.
  - Then drop req and go to XFER.
- **State XFER.**
  - Wait for cmplt.
  - On cmplt: burst_addr += len and remaining −= len.
  - If remaining ≠ 0, go to WAIT_SPACE.
  - Otherwise go to LINE_END.
- **State LINE_END** (one cycle).
  - If line_idx == vres−1: go to DONE.
  - Otherwise: line_idx++, line_addr += line_stride·4 (stride·4 is precomputed in a register, so there is no runtime multiply), burst_addr=line_addr, remaining=hres*4, and go to WAIT_SPACE.
- **State DONE.**
  - Set busy=0.
  - frame_done or frame_start returns to IDLE. A frame_start arriving in DONE is handled as in IDLE in the same cycle.
- **Restart during a frame.**
  - A frame_start while busy sets restart_pend.
  - In WAIT_SPACE or LINE_END, restart_pend forces a frame reload (same actions as IDLE) and clears restart_pend.
  - An outstanding REQ/XFER is never abandoned. The restart takes effect after cmplt.
- **Errors.**
  - cmplt with error=1 sets err_sticky. The fetch continues as if the burst succeeded.
  - err_sticky clears only on reset.
- **enable=0.**
  - Blocks the WAIT_SPACE→REQ transition and frame starts from IDLE.
  - Does not cancel an accepted command.
- **hres.** Values that are not a multiple of BURST_BYTES/4 produce a short final burst. hres=0 or vres=0: the frame completes immediately (IDLE→DONE), with no commands issued.

## Timing

- **Reset values:** req=0, addr=0, length=0, busy=0, line_idx=0, err_sticky=0, state IDLE, restart_pend=0.
- **Outputs:** all are registered.
- **Command latency:**
  - frame_start to first req=1 is 2 cycles, provided there is FIFO space.
  - cmplt to the next req=1 within the same line is 2 cycles.
  - cmplt on the last burst of a line to the first req of the next line is 3 cycles (the extra cycle is LINE_END).
- **Request hold:** req stays high for at least 1 cycle. If cmdack arrives in the first req cycle, req is low on the next cycle.
- **Ignored inputs:** cmplt without an outstanding command and cmdack outside REQ are ignored.

## Test plan

- **Basic frame.** hres=64, vres=2, stride=64, base=0xA8000000, fifo_count=0, cmdack/cmplt returned 3 cycles after each req.
  - Required: 4 commands of 128 bytes at 0xA8000000, 0xA8000080, 0xA8000100, 0xA8000180.
  - Then busy=0.
- **Short last burst.** hres=40.
  - Required: lengths 128 then 32. The second line starts at base+stride·4.
- **FIFO backpressure.** fifo_count=FIFO_DEPTH−16.
  - Required: req stays low.
  - Lowering fifo_count to FIFO_DEPTH−32 produces req 2 cycles later.
- **Restart mid-XFER.** Pulse frame_start while a burst is outstanding.
  - Required: no new req before cmplt.
  - The next command is at frame_base with line_idx=0.
- **Error.** cmplt with error=1.
  - Required: err_sticky=1 from the next cycle.
  - The address still advances by len, and the flag persists until Bus2IP_Resetn=0.
- **Reset mid-REQ.** Bus2IP_Resetn=0 for 1 cycle while req=1.
  - Required: req=0 and busy=0 the next cycle.
  - No command is issued until a new frame_start.
